// File: rtl/datain_sink_chk_if.sv
// Ejection-port bundle for datain_sink_chk: the incoming flit stream and the capture-buffer read port.
// The rd_ts member exists only when SINK_TIMESTAMP_EN is defined.
interface datain_sink_chk_if;
  logic [19:0] datain;
  logic        in_valid;
  logic        rd_en;
  logic [19:0] rd_data;
  logic        rd_valid;
`ifdef SINK_TIMESTAMP_EN
  logic [15:0] rd_ts;

  modport master (output datain, in_valid, rd_en, input rd_data, rd_valid, rd_ts);
  modport slave  (input datain, in_valid, rd_en, output rd_data, rd_valid, rd_ts);
`else
  modport master (output datain, in_valid, rd_en, input rd_data, rd_valid);
  modport slave  (input datain, in_valid, rd_en, output rd_data, rd_valid);
`endif
endinterface

// File: rtl/datain_sink_chk.sv
// Ejection-port sink: captures flits into a readable buffer and checks them against the uniform-traffic format.
// Optional macro SINK_TIMESTAMP_EN stores a 16-bit cycle stamp with every captured flit and returns it on rd_ts.
//
// Handshake: in_valid has no backpressure and is sampled every cycle; rd_en pops one entry when level != 0,
// and the popped word appears on rd_data with a one-cycle rd_valid pulse on the following cycle.
module datain_sink_chk #(
  parameter int DEPTH      = 30,
  parameter int LOCAL_ID   = 0,
  parameter int NUM_SRC    = 4,
  parameter int EXPECT_CNT = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  datain_sink_chk_if.slave           bus,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [15:0]                rx_count,
  output logic [7:0]                 err_count,
  output logic                       misroute_err,
  output logic                       bad_src_err,
  output logic                       order_err,
  output logic                       overflow,
  output logic                       done
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [19:0]      mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [19:0]      rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic [15:0]      rx_count_q, rx_count_d;
  logic [7:0]       err_count_q, err_count_d;
  logic             misroute_q, misroute_d, bad_src_q, bad_src_d, order_q, order_d;
  logic             overflow_q, overflow_d, done_q, done_d;
  logic [15:0][7:0] last_seq_q, last_seq_d;

  logic [7:0] src, seq;
  logic [3:0] dl;
  logic       src_ok, mis_hit, ord_hit, any_err, rd_acc, wr_en;

  always_comb begin
    src     = bus.datain[19:12];
    seq     = bus.datain[11:4];
    dl      = bus.datain[3:0];
    src_ok  = src < 8'(NUM_SRC);
    mis_hit = dl != 4'(LOCAL_ID);
    // Only strict increase is required: each port sees a strided subset of a source's stream.
    ord_hit = src_ok && (seq <= last_seq_q[src[3:0]]);
    any_err = mis_hit || !src_ok || ord_hit;
    rd_acc  = bus.rd_en && (level_q != '0);
    // A read in the same cycle frees a slot, so a full buffer still accepts the write.
    wr_en   = bus.in_valid && ((level_q < LW'(DEPTH)) || rd_acc);
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = rd_acc;
    rx_count_d  = rx_count_q;
    err_count_d = err_count_q;
    misroute_d  = misroute_q;
    bad_src_d   = bad_src_q;
    order_d     = order_q;
    overflow_d  = overflow_q;
    last_seq_d  = last_seq_q;
    done_d      = done_q || (rx_count_q >= 16'(EXPECT_CNT));

    if (wr_en)
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (rd_acc) begin
      rd_ptr_d  = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      rd_data_d = mem[rd_ptr_q];
    end
    case ({wr_en, rd_acc})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    if (bus.in_valid) begin
      if (rx_count_q != 16'hFFFF) rx_count_d = rx_count_q + 1'b1;
      if (any_err && err_count_q != 8'hFF) err_count_d = err_count_q + 1'b1;
      if (mis_hit) misroute_d = 1'b1;
      if (!src_ok) bad_src_d  = 1'b1;
      if (ord_hit) order_d    = 1'b1;
      if (!wr_en)  overflow_d = 1'b1;
      if (src_ok)  last_seq_d[src[3:0]] = seq;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      rx_count_q  <= '0;
      err_count_q <= '0;
      misroute_q  <= 1'b0;
      bad_src_q   <= 1'b0;
      order_q     <= 1'b0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
      last_seq_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      rx_count_q  <= rx_count_d;
      err_count_q <= err_count_d;
      misroute_q  <= misroute_d;
      bad_src_q   <= bad_src_d;
      order_q     <= order_d;
      overflow_q  <= overflow_d;
      done_q      <= done_d;
      last_seq_q  <= last_seq_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= bus.datain;
  end

`ifdef SINK_TIMESTAMP_EN
  logic [15:0] ts_mem [DEPTH];
  logic [15:0] ts_q, ts_d, rd_ts_q, rd_ts_d;

  always_comb begin
    ts_d    = ts_q + 1'b1;
    rd_ts_d = rd_acc ? ts_mem[rd_ptr_q] : rd_ts_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_q    <= '0;
      rd_ts_q <= '0;
    end else begin
      ts_q    <= ts_d;
      rd_ts_q <= rd_ts_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) ts_mem[wr_ptr_q] <= ts_q;
  end

  assign bus.rd_ts = rd_ts_q;
`endif

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign level        = level_q;
  assign rx_count     = rx_count_q;
  assign err_count    = err_count_q;
  assign misroute_err = misroute_q;
  assign bad_src_err  = bad_src_q;
  assign order_err    = order_q;
  assign overflow     = overflow_q;
  assign done         = done_q;
endmodule

// File: tb/tb_datain_sink_chk.sv
// Directed bench for datain_sink_chk (DEPTH=30, LOCAL_ID=0, NUM_SRC=4, EXPECT_CNT=8).
module tb_datain_sink_chk;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] level;
  logic [15:0] rx_count;
  logic [7:0] err_count;
  logic       misroute_err, bad_src_err, order_err, overflow, done;
  int         vectors = 0;
  int         miscompares = 0;
  logic [19:0] exp_q[$];
  logic [19:0] clean_v [8];

  datain_sink_chk_if bus();

  datain_sink_chk #(.DEPTH(30), .LOCAL_ID(0), .NUM_SRC(4), .EXPECT_CNT(8)) dut (
    .clk(clk), .rst(rst), .bus(bus), .level(level), .rx_count(rx_count),
    .err_count(err_count), .misroute_err(misroute_err), .bad_src_err(bad_src_err),
    .order_err(order_err), .overflow(overflow), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [19:0] d);
    @(negedge clk);
    bus.datain   = d;
    bus.in_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.rd_en    = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic pop_chk(input string tag);
    logic [19:0] e;
    @(negedge clk);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    e = exp_q.pop_front();
    chk({tag, "_rd_valid"}, 32'(bus.rd_valid), 32'd1);
    chk({tag, "_rd_data"}, 32'(bus.rd_data), 32'(e));
  endtask

  task automatic chk_status(input string tag, input int lv, input int rx, input int er,
                            input logic mis, input logic bad, input logic ord,
                            input logic ovf, input logic dn);
    chk({tag, "_level"}, 32'(level), 32'(lv));
    chk({tag, "_rx_count"}, 32'(rx_count), 32'(rx));
    chk({tag, "_err_count"}, 32'(err_count), 32'(er));
    chk({tag, "_misroute"}, 32'(misroute_err), 32'(mis));
    chk({tag, "_bad_src"}, 32'(bad_src_err), 32'(bad));
    chk({tag, "_order"}, 32'(order_err), 32'(ord));
    chk({tag, "_overflow"}, 32'(overflow), 32'(ovf));
    chk({tag, "_done"}, 32'(done), 32'(dn));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.rd_en    = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic clean_stream(input string tag);
    for (int i = 0; i < 8; i++) begin
      send(clean_v[i]);
      exp_q.push_back(clean_v[i]);
    end
    idle(2);
    chk_status(tag, 8, 8, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) pop_chk(tag);
    @(negedge clk);
    chk({tag, "_rd_valid_pulse"}, 32'(bus.rd_valid), 32'd0);
    chk({tag, "_level_empty"}, 32'(level), 32'd0);
  endtask

  initial begin
    clean_v = '{20'h02010, 20'h02050, 20'h02090, 20'h020D0,
                20'h02110, 20'h02150, 20'h02190, 20'h021D0};
    bus.datain   = '0;
    bus.in_valid = 1'b0;
    bus.rd_en    = 1'b0;

    // 1: reset held while inputs toggle, then released and idle
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.datain   = 20'($urandom_range(0, 20'hFFFFF));
      bus.in_valid = 1'b1;
      bus.rd_en    = 1'b1;
    end
    @(negedge clk);
    chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk_status("rst_held", 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    bus.rd_en    = 1'b0;
    rst          = 1'b1;
    idle(5);
    chk("idle_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk_status("idle", 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // 2: clean stream
    clean_stream("clean");

    // 3: misroute and bad source
    do_reset();
    send(20'h02021); exp_q.push_back(20'h02021);
    send(20'h09010); exp_q.push_back(20'h09010);
    idle(2);
    chk_status("errs", 2, 2, 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    pop_chk("errs");
    pop_chk("errs");

    // 4: ordering; a smaller seq is an error, then a larger one is clean again
    do_reset();
    send(20'h02050);
    send(20'h02010);
    idle(2);
    chk_status("order", 2, 2, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send(20'h02090);
    idle(2);
    chk_status("order2", 3, 3, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // 5: overflow; flit 31 is dropped but still counted and checked
    do_reset();
    for (int i = 1; i <= 31; i++) begin
      send({8'h00, 8'(i), 4'h0});
      if (i <= 30) exp_q.push_back({8'h00, 8'(i), 4'h0});
    end
    idle(2);
    chk_status("ovf", 30, 31, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 30; i++) pop_chk("ovf_drain");
    @(negedge clk);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    chk("empty_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("empty_rd_hold", 32'(bus.rd_data), 32'h001E0);
    chk("empty_level", 32'(level), 32'd0);
    for (int i = 32; i <= 61; i++) begin
      send({8'h00, 8'(i), 4'h0});
      exp_q.push_back({8'h00, 8'(i), 4'h0});
    end
    idle(1);
    chk("refill_level", 32'(level), 32'd30);
    @(negedge clk);
    bus.datain   = {8'h00, 8'd62, 4'h0};
    bus.in_valid = 1'b1;
    bus.rd_en    = 1'b1;
    exp_q.push_back({8'h00, 8'd62, 4'h0});
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.rd_en    = 1'b0;
    chk("full_rw_rd_valid", 32'(bus.rd_valid), 32'd1);
    chk("full_rw_rd_data", 32'(bus.rd_data), 32'(exp_q.pop_front()));
    chk_status("full_rw", 30, 62, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 30; i++) pop_chk("full_rw_drain");

    // 6: reset in the middle of a stream, then a full clean stream
    do_reset();
    for (int i = 0; i < 4; i++) send(clean_v[i]);
    idle(2);
    chk("mid_pre_rx", 32'(rx_count), 32'd4);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk_status("mid_rst", 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    clean_stream("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
